add4_rr_arbiter: RTL
====================

# add4_rr_arbiter

Round-robin arbiter and sequencer that shares a single WIDTH-bit adder datapath between NREQ requesters. Each requester presents two operands and a request. The block grants one requester at a time and latches its operands. It computes the registered sum and carry, then holds the result with the winner's ID until the consumer accepts it. It sits between the stimulus/driver side and the shared adder, so several agents can reuse one adder instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 4, operand/sum width in bits
- IDW, $clog2(NREQ), width of requester ID

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- a_flat  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- b_flat  in  NREQ*WIDTH  operand B, same packing
- gnt  out  NREQ  one-hot grant; operands of the granted requester are sampled at this edge
- busy  out  1  high in EXEC and DONE
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that owns the result
- rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH
- rsp_carry  out  1  carry out of the WIDTH-bit add

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req is high, pick a winner by round-robin, searching upward from ptr with wrap.
  - Drive gnt[winner]=1 combinationally.
  - At the clock edge: latch A/B of the winner into op registers, latch winner into id_r, set ptr <= (winner+1) mod NREQ, go to EXEC.
  - If no req is high: gnt=0, stay in IDLE, ptr unchanged.
- EXEC:
  - Compute {carry,sum} = op_a + op_b as a (WIDTH+1)-bit zero-extended add.
  - Register the result into rsp_sum/rsp_carry and go to DONE.
  - req is ignored; gnt=0.
- DONE:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_carry are stable.
  - If rsp_ready=1 at the edge, go to IDLE; otherwise hold all response outputs unchanged.
  - req is ignored; gnt=0.
- Requesters must hold operands stable while req is high. A req still high in the next IDLE is a new request.
- Operand changes after the gnt edge do not affect the in-flight result.
- ptr: IDW bits; with non-power-of-2 NREQ it wraps from NREQ-1 to 0.

## Timing
- Reset (rst high at an edge, from any state):
  - next cycle: state IDLE, ptr=0, id_r=0, op regs=0
  - outputs: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0
  - gnt is forced to 0 in every cycle rst is high
  - any in-flight result is discarded, not delivered
- Latency: gnt in cycle C0 -> rsp_valid=1 in cycle C0+2.
- Throughput: with rsp_ready tied high, one grant every 3 cycles (IDLE, EXEC, DONE).
- Backpressure: rsp_ready low in DONE stalls indefinitely; no new grants while stalled.
- rsp_valid rises only on entry to DONE and falls in the cycle after the accepting edge.
- Simultaneous requests: exactly one gnt bit per grant cycle; never more than one.
- Fairness: with all req held high, grants go 0,1,2,...,NREQ-1,0,...
- Wrap-around:
  - arithmetic: 15+1 at WIDTH=4 gives sum 0, carry 1
  - all-ones: 15+15 gives sum 14, carry 1
- rsp_ready high outside DONE: no effect.

## Test plan
- Reset: hold rst 2 cycles mid-run (state EXEC) -> next cycle IDLE, all outputs 0, no rsp_valid for discarded op, next grant goes to req[0] if asserted.
- Single op: req[0]=1, a0=4'b0100, b0=4'b1100, rsp_ready=1 -> gnt[0] in C0, rsp_valid in C2 with rsp_id=0, rsp_sum=0, rsp_carry=1.
- Round-robin: all four req held high with a_i=i, b_i=5, rsp_ready=1 -> grant order 0,1,2,3,0, one per 3 cycles; sums 5,6,7,8, carry 0.
- Backpressure: req[2]=1, a2=2, b2=5, rsp_ready low for 4 cycles after rsp_valid -> outputs (id=2, sum=7, carry=0) held; no gnt while stalled; accept -> IDLE next cycle.
- Operand hazard: req[1] a1=5, b1=7, change a1 to 0 in the cycle after gnt -> rsp_sum=12, carry 0.
- Skip/wrap: ptr=3 after granting 2; only req[1] high -> gnt[1]; then req[0] and req[3] high -> gnt[3] before gnt[0].

Source files
------------

// File: rtl/add4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// add4_rr_arbiter : round-robin sequencer sharing one WIDTH-bit adder
// Rev 1.0
// ============================================================================
module add4_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  input  logic [NREQ*WIDTH-1:0] b_flat,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_cand;
  logic [IDW-1:0]   w_win_next;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_a [NREQ];
  logic [WIDTH-1:0] w_b [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a[gi] = a_flat[gi*WIDTH +: WIDTH];
    assign w_b[gi] = b_flat[gi*WIDTH +: WIDTH];
  end

  // First requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_win_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
  assign w_add      = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    gnt     = '0;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          gnt     = NREQ'(1) << w_win;
          op_a_d  = w_a[w_win];
          op_b_d  = w_b[w_win];
          id_d    = w_win;
          ptr_d   = w_win_next;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        sum_d   = w_add[WIDTH-1:0];
        carry_d = w_add[WIDTH];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A grant must never be seen by a requester while reset is asserted.
    if (rst) begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;

endmodule
`default_nettype wire
